// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: 2*WIDTH-bit signed/unsigned product of two WIDTH-bit operands.
// Latency: start at edge E0, done pulse and valid product after edge E(WIDTH+1); one op per WIDTH+1 cycles.
// Backpressure: none; start is ignored while busy, results hold until the next completion or reset.
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter runs 0..WIDTH: WIDTH iteration cycles plus one cycle to sign-fix and register the result.
    localparam int              CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mult_q, mult_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 sign_q, sign_d;
    logic [WIDTH-1:0]     prod_hi_q, prod_hi_d;
    logic [WIDTH-1:0]     prod_lo_q, prod_lo_d;

    logic                 accept;
    logic                 neg_a, neg_b;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   prod_full;

    // A new operation is taken whenever the block is not iterating (IDLE or the DONE cycle).
    assign accept = start && (state_q != S_RUN);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (cnt_q == LAST) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    assign prod_hi = prod_hi_q;
    assign prod_lo = prod_lo_q;

    // Operand magnitudes and the per-cycle partial-sum add (carry kept in bit WIDTH).
    always_comb begin
        neg_a     = is_signed & op_a[WIDTH-1];
        neg_b     = is_signed & op_b[WIDTH-1];
        mag_a     = neg_a ? (-op_a) : op_a;
        mag_b     = neg_b ? (-op_b) : op_b;
        sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mult_q[0] ? {1'b0, mcand_q} : '0);
        prod_full = sign_q ? (-acc_q) : acc_q;
    end

    // Datapath next values: latch on accept, iterate in RUN, register the signed result on the last RUN cycle.
    always_comb begin
        mcand_d   = mcand_q;
        mult_d    = mult_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        prod_hi_d = prod_hi_q;
        prod_lo_d = prod_lo_q;
        if (accept) begin
            mcand_d = mag_a;
            mult_d  = mag_b;
            sign_d  = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            acc_d   = '0;
            cnt_d   = '0;
        end else if (state_q == S_RUN) begin
            if (cnt_q != LAST) begin
                // Shift {carry, acc, multiplier} right by one; the bit leaving acc enters the multiplier MSB.
                acc_d  = {sum, acc_q[WIDTH-1:1]};
                mult_d = {acc_q[0], mult_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CW'(1);
            end else begin
                prod_hi_d = prod_full[2*WIDTH-1:WIDTH];
                prod_lo_d = prod_full[WIDTH-1:0];
            end
        end
    end

    // Datapath registers; reset discards any in-flight operation and clears the held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q   <= '0;
            mult_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            prod_hi_q <= '0;
            prod_lo_q <= '0;
        end else begin
            mcand_q   <= mcand_d;
            mult_q    <= mult_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            prod_hi_q <= prod_hi_d;
            prod_lo_q <= prod_lo_d;
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed corner cases plus randomized operations against an arithmetic model.
// Latency: expects done exactly WIDTH+1 edges after the start edge.
// Backpressure: exercises start-while-busy, back-to-back starts in the done cycle and reset mid-operation.
module tb_seq_multiplier;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic         is_signed;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] prod_hi;
    logic [W-1:0] prod_lo;

    int           checks;
    int           failures;
    logic [63:0]  last_prod;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .prod_hi   (prod_hi),
        .prod_lo   (prod_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference product computed with plain 64-bit arithmetic.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge: presents a start request for the next rising edge.
    task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input logic s);
        start     = 1'b1;
        op_a      = a;
        op_b      = b;
        is_signed = s;
    endtask

    // Runs one operation whose start is already driven; optionally re-pulses start mid-run
    // and optionally chains the next operation's start into the done cycle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int repulse_at, input bit chain,
                          input logic [31:0] ca, input logic [31:0] cb, input logic cs);
        logic [63:0] exp;
        int          n;
        int          done_n;
        int          busy_cnt;
        exp      = ref_mul(a, b, s);
        done_n   = -1;
        busy_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        n         = 0;
        start     = 1'b0;
        op_a      = $urandom;
        op_b      = $urandom;
        is_signed = 1'($urandom_range(0, 1));
        if (busy && !done) busy_cnt++;
        while (n < 40 && done_n < 0) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            start = 1'b0;
            op_a  = $urandom;
            op_b  = $urandom;
            if (n == repulse_at) begin
                start = 1'b1;
                op_a  = 32'd9;
            end
            if (n == 16) check("hold_during_run", {prod_hi, prod_lo}, last_prod);
            if (done) done_n = n;
            else if (busy) busy_cnt++;
        end
        check("done_latency", 64'(done_n), 64'd33);
        check("busy_cycles", 64'(busy_cnt), 64'd33);
        check("busy_at_done", 64'(busy), 64'd0);
        check("product", {prod_hi, prod_lo}, exp);
        last_prod = exp;
        if (chain) begin
            drive_start(ca, cb, cs);
        end else begin
            @(posedge clk);
            @(negedge clk);
            check("done_one_cycle", 64'(done), 64'd0);
            check("product_held", {prod_hi, prod_lo}, last_prod);
        end
    endtask

    // Watches an idle stretch: no done pulse may appear and the result must stay put.
    task automatic idle_watch(input int cycles);
        int pulses;
        pulses = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("no_extra_done", 64'(pulses), 64'd0);
        check("idle_hold", {prod_hi, prod_lo}, last_prod);
    endtask

    localparam int NR = 24;
    logic [31:0] ra [NR];
    logic [31:0] rb [NR];
    logic        rs [NR];

    initial begin
        bit pend;
        bit ch;
        checks    = 0;
        failures  = 0;
        last_prod = '0;
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        op_a      = '0;
        op_b      = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_prod", {prod_hi, prod_lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {62'd0, busy, done}, 64'd0);

        // Directed cases.
        drive_start(32'd3, 32'd5, 1'b0);
        run_op(32'd3, 32'd5, 1'b0, -1, 1'b0, '0, '0, 1'b0);
        drive_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, 1'b0, '0, '0, 1'b0);
        drive_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, -1, 1'b0, '0, '0, 1'b0);
        drive_start(32'hFFFF_FFFD, 32'd7, 1'b1);
        run_op(32'hFFFF_FFFD, 32'd7, 1'b1, -1, 1'b0, '0, '0, 1'b0);
        check("neg3x7_const", {prod_hi, prod_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        drive_start(32'h8000_0000, 32'h8000_0000, 1'b1);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, -1, 1'b0, '0, '0, 1'b0);
        check("min_sq_const", {prod_hi, prod_lo}, 64'h4000_0000_0000_0000);

        // Start while busy is ignored; no second done follows.
        drive_start(32'd6, 32'd7, 1'b0);
        run_op(32'd6, 32'd7, 1'b0, 10, 1'b0, '0, '0, 1'b0);
        idle_watch(40);

        // Back-to-back: second start presented in the done cycle.
        drive_start(32'd6, 32'd7, 1'b0);
        run_op(32'd6, 32'd7, 1'b0, -1, 1'b1, 32'd2, 32'd2, 1'b0);
        run_op(32'd2, 32'd2, 1'b0, -1, 1'b0, '0, '0, 1'b0);

        // Reset in the middle of an operation.
        drive_start(32'd100, 32'd200, 1'b0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_state", {62'd0, busy, done}, 64'd0);
        check("midrst_prod", {prod_hi, prod_lo}, 64'd0);
        last_prod = '0;
        idle_watch(40);
        drive_start(32'd12, 32'hFFFF_FFF0, 1'b1);
        run_op(32'd12, 32'hFFFF_FFF0, 1'b1, -1, 1'b0, '0, '0, 1'b0);

        // Randomized operations, some chained into the done cycle.
        for (int i = 0; i < NR; i++) begin
            ra[i] = pick_operand();
            rb[i] = pick_operand();
            rs[i] = 1'($urandom_range(0, 1));
        end
        pend = 1'b0;
        for (int i = 0; i < NR; i++) begin
            if (!pend) drive_start(ra[i], rb[i], rs[i]);
            ch = (i < NR - 1) && ($urandom_range(0, 1) == 1);
            if (ch) run_op(ra[i], rb[i], rs[i], -1, 1'b1, ra[i+1], rb[i+1], rs[i+1]);
            else    run_op(ra[i], rb[i], rs[i], -1, 1'b0, '0, '0, 1'b0);
            pend = ch;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
